result_history: RTL and testbench

Parametrised result store that keeps the last DEPTH ALU results in a circular buffer, replacing the single-entry result register. Each capture writes the value into the buffer. Step inputs let the user browse older results on the board display. It sits between the ALU output and the display driver, and it reports fill level and overwrite status.

---
 rtl/result_history.sv | 99 +++++++++
 tb/tb_result_history.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/result_history.sv
// Circular store of the last DEPTH ALU results with a browsable view.
// Sits between the ALU output and the display driver.
module result_history #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [WIDTH-1:0]           D,
  input  logic                       clear,
  input  logic                       step_back,
  input  logic                       step_fwd,
  output logic [WIDTH-1:0]           Q,
  output logic [WIDTH-1:0]           latest,
  output logic [$clog2(DEPTH)-1:0]   view_age,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wp_q, wp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] age_q, age_d;
  logic          ovf_q, ovf_d;
  logic          we;

  logic [AW-1:0] lat_ptr;
  logic [AW-1:0] view_ptr;

  always_comb begin
    wp_d  = wp_q;
    cnt_d = cnt_q;
    age_d = age_q;
    ovf_d = ovf_q;
    we    = 1'b0;
    if (clear) begin
      wp_d  = '0;
      cnt_d = '0;
      age_d = '0;
      ovf_d = 1'b0;
    end else if (enable) begin
      we    = 1'b1;
      wp_d  = wp_q + AW'(1);
      age_d = '0;
      if (cnt_q == DEPTH_C) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + (AW+1)'(1);
      end
    end else if (step_back && !step_fwd) begin
      // never browse past the oldest valid entry
      if (({1'b0, age_q} + (AW+1)'(1)) < cnt_q) begin
        age_d = age_q + AW'(1);
      end
    end else if (step_fwd && !step_back) begin
      if (age_q != '0) begin
        age_d = age_q - AW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wp_q  <= '0;
      cnt_q <= '0;
      age_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
      age_q <= age_d;
      ovf_q <= ovf_d;
    end
  end

  // storage has no reset; the count mask hides stale contents
  always_ff @(posedge clock) begin
    if (reset && we) begin
      mem[wp_q] <= D;
    end
  end

  assign lat_ptr  = wp_q - AW'(1);
  assign view_ptr = wp_q - AW'(1) - age_q;

  assign latest   = (cnt_q != '0) ? mem[lat_ptr]  : '0;
  assign Q        = (cnt_q != '0) ? mem[view_ptr] : '0;
  assign view_age = age_q;
  assign count    = cnt_q;
  assign full     = (cnt_q == DEPTH_C);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_result_history.sv
// Bench for result_history: queue-based history model feeds a
// scoreboard of expected outputs, popped after each clock edge.
module tb_result_history;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [8:0] d;
  logic       clr;
  logic       sb;
  logic       sf;
  logic [8:0] q;
  logic [8:0] lat;
  logic [2:0] age;
  logic [3:0] cnt;
  logic       full;
  logic       ovf;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int q;
    int lat;
    int age;
    int cnt;
    int full;
    int ovf;
  } exp_t;

  exp_t exp_q[$];

  logic [8:0] hist[$];
  int m_age = 0;
  int m_ovf = 0;

  result_history #(.WIDTH(9), .DEPTH(8)) dut (
    .clock     (clk),
    .reset     (rst_n),
    .enable    (en),
    .D         (d),
    .clear     (clr),
    .step_back (sb),
    .step_fwd  (sf),
    .Q         (q),
    .latest    (lat),
    .view_age  (age),
    .count     (cnt),
    .full      (full),
    .overflow  (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic r, input logic e,
                       input logic c, input logic b,
                       input logic f, input logic [8:0] v);
    exp_t x;
    if (!r || c) begin
      hist.delete();
      m_age = 0;
      m_ovf = 0;
    end else if (e) begin
      if (hist.size() == 8) m_ovf = 1;
      hist.push_front(v);
      if (hist.size() > 8) void'(hist.pop_back());
      m_age = 0;
    end else if (b && !f) begin
      if (m_age + 1 < hist.size()) m_age++;
    end else if (f && !b) begin
      if (m_age > 0) m_age--;
    end
    x.q    = (hist.size() > 0) ? int'(hist[m_age]) : 0;
    x.lat  = (hist.size() > 0) ? int'(hist[0]) : 0;
    x.age  = m_age;
    x.cnt  = hist.size();
    x.full = (hist.size() == 8) ? 1 : 0;
    x.ovf  = m_ovf;
    exp_q.push_back(x);
  endtask

  task automatic cyc(input logic r, input logic e,
                     input logic c, input logic b,
                     input logic f, input logic [8:0] v);
    exp_t x;
    rst_n = r;
    en    = e;
    clr   = c;
    sb    = b;
    sf    = f;
    d     = v;
    model(r, e, c, b, f, v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL scoreboard: empty queue");
    end else begin
      x = exp_q.pop_front();
      chk("Q",        32'(q),    32'(x.q));
      chk("latest",   32'(lat),  32'(x.lat));
      chk("view_age", 32'(age),  32'(x.age));
      chk("count",    32'(cnt),  32'(x.cnt));
      chk("full",     32'(full), 32'(x.full));
      chk("overflow", 32'(ovf),  32'(x.ovf));
    end
  endtask

  task automatic cap(input logic [8:0] v);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, v);
  endtask

  task automatic back();
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'h0);
  endtask

  task automatic fwd();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'h0);
  endtask

  task automatic clr1();
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b0; d = '0; clr = 1'b0; sb = 1'b0; sf = 1'b0;
    #1;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h155);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h155);
    chk("rst_Q", 32'(q), 32'h0);
    chk("rst_cnt", 32'(cnt), 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h0);

    cap(9'h001);
    cap(9'h1FF);
    cap(9'h0AA);
    chk("cap_latest", 32'(lat), 32'h0AA);
    chk("cap_Q", 32'(q), 32'h0AA);
    chk("cap_cnt", 32'(cnt), 32'd3);
    back();
    chk("back1_Q", 32'(q), 32'h1FF);
    back();
    chk("back2_Q", 32'(q), 32'h001);
    back();
    chk("back3_Q", 32'(q), 32'h001);
    chk("back3_age", 32'(age), 32'd2);
    fwd(); fwd(); fwd();
    chk("fwd_Q", 32'(q), 32'h0AA);
    chk("fwd_age", 32'(age), 32'd0);

    clr1();
    for (int i = 1; i <= 8; i++) cap(9'(i));
    chk("wrap_full", 32'(full), 32'd1);
    chk("wrap_ovf0", 32'(ovf), 32'd0);
    cap(9'd9);
    chk("wrap_ovf1", 32'(ovf), 32'd1);
    chk("wrap_lat", 32'(lat), 32'd9);
    chk("wrap_cnt", 32'(cnt), 32'd8);
    for (int i = 0; i < 7; i++) back();
    chk("oldest_Q", 32'(q), 32'd2);
    back();
    chk("oldest_hold", 32'(q), 32'd2);
    cap(9'd10);
    chk("ovf_sticky", 32'(ovf), 32'd1);

    clr1();
    for (int i = 0; i < 5; i++) cap(9'(9'h020 + 9'(i)));
    back(); back(); back();
    chk("browse_age", 32'(age), 32'd3);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 9'h07F);
    chk("cdb_Q", 32'(q), 32'h07F);
    chk("cdb_age", 32'(age), 32'd0);
    chk("cdb_cnt", 32'(cnt), 32'd6);

    back(); back();
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 9'h0);
    chk("both_age", 32'(age), 32'd2);
    chk("both_Q", 32'(q), 32'h023);

    for (int i = 0; i < 4; i++) cap(9'(9'h100 + 9'(i)));
    chk("pre_clr_ovf", 32'(ovf), 32'd1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'h1EE);
    chk("clr_cnt", 32'(cnt), 32'd0);
    chk("clr_lat", 32'(lat), 32'd0);
    cap(9'h003);
    chk("post_cnt", 32'(cnt), 32'd1);
    chk("post_Q", 32'(q), 32'h003);

    back();
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 9'h044);
    chk("midrst_cnt", 32'(cnt), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
